gate_truth_table_checker: RTL and testbench

Self-checking stimulus/response stage for the mux-built logic-gate block. It drives a,b through all four input combinations, waits a programmable settle time, samples the six gate outputs and compares them to the ideal truth table. It accumulates error status and reports pass/fail. This replaces open-loop $monitor inspection with a synthesizable sequencer and checker.

---
 rtl/gate_check_pkg.sv | 32 +++
 rtl/gate_check_expect_lut.sv | 12 +
 rtl/gate_truth_table_checker.sv | 126 ++++++++++++
 tb/tb_gate_truth_table_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate truth-table checker: FSM states, gate bit
// positions and the ideal two-input gate truth table.
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NAND = 2;
    localparam int GATE_NOR  = 3;
    localparam int GATE_XOR  = 4;
    localparam int GATE_XNOR = 5;
    localparam int GATE_W    = 6;

    function automatic logic [GATE_W-1:0] expected_y(input logic a, input logic b);
        logic [GATE_W-1:0] e;
        e            = '0;
        e[GATE_AND]  = a & b;
        e[GATE_OR]   = a | b;
        e[GATE_NAND] = ~(a & b);
        e[GATE_NOR]  = ~(a | b);
        e[GATE_XOR]  = a ^ b;
        e[GATE_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_check_expect_lut.sv
// Combinational golden model: maps the stimulus index {a,b} to the six ideal
// gate outputs. Kept separate so a different reference can be dropped in.
module gate_expect_lut
    import gate_check_pkg::*;
(
    input  logic [1:0]        idx,
    output logic [GATE_W-1:0] y_exp
);

    assign y_exp = expected_y(idx[1], idx[0]);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sequencer and checker: steps {a,b} through 00..11, lets the gate block
// settle, compares its outputs to the truth table and accumulates errors.
module gate_truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [5:0]       err_vec,
    output logic [1:0]       first_fail_idx,
    output logic             first_fail_valid
);

    localparam logic [3:0]       CNT_LOAD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LOOP_LAST = 4'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t      state;
    logic [1:0]  idx;
    logic [3:0]  loop;
    logic [3:0]  cnt;
    logic [5:0]  y_exp;
    logic [5:0]  diff;
    logic [ERR_W-1:0] err_next;

    gate_expect_lut u_lut (
        .idx   (idx),
        .y_exp (y_exp)
    );

    // Case inequality so that X/Z on y is reported as a mismatch in simulation.
    always_comb begin
        diff = '0;
        for (int i = 0; i < GATE_W; i++) begin
            diff[i] = (y[i] !== y_exp[i]);
        end
    end

    always_comb begin
        err_next = err_count;
        if ((diff != '0) && (err_count != ERR_MAX)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            idx              <= '0;
            loop             <= '0;
            cnt              <= '0;
            a                <= 1'b0;
            b                <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            err_vec          <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx              <= '0;
                        loop             <= '0;
                        cnt              <= CNT_LOAD;
                        a                <= 1'b0;
                        b                <= 1'b0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        err_vec          <= '0;
                        first_fail_idx   <= '0;
                        first_fail_valid <= 1'b0;
                        state            <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    err_vec   <= err_vec | diff;
                    err_count <= err_next;
                    if ((diff != '0) && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                    if ((idx == 2'd3) && (loop == LOOP_LAST)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= ST_DONE;
                    end else begin
                        // Index wraps 3->0; the wrap marks the end of one pass.
                        idx    <= idx + 2'd1;
                        {a, b} <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            loop <= loop + 4'd1;
                        end
                        cnt   <= CNT_LOAD;
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a behavioural gate block with selectable
// faults feeds three checker instances (default, LOOPS=3, ERR_W=2/LOOPS=2).
module tb_gate_truth_table_checker;

    logic clk, rst;
    logic start0, start1, start2;
    logic [5:0] y0, y1, y2;
    logic a0, b0, a1, b1, a2, b2;
    logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [7:0] err0, err1;
    logic [1:0] err2;
    logic [5:0] vec0, vec1, vec2;
    logic [1:0] ffi0, ffi1, ffi2;
    logic ffv0, ffv1, ffv2;

    int checks, failures, fault_mode, sel, n;
    logic [1:0] ab_log [0:63];
    logic       busy_log [0:63];
    logic       obs_done, obs_busy;
    logic [1:0] obs_ab;

    // 0 golden, 1 XOR stuck-at-0, 2 NAND/NOR swapped, 3 all inverted, 4 all X
    function automatic logic [5:0] model_y(input logic a, input logic b, input int mode);
        logic [5:0] g;
        g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
        case (mode)
            1: g[4] = 1'b0;
            2: g = {g[5:4], g[2], g[3], g[1:0]};
            3: g = ~g;
            4: g = 6'bxxxxxx;
            default: ;
        endcase
        return g;
    endfunction

    assign y0 = model_y(a0, b0, fault_mode);
    assign y1 = model_y(a1, b1, fault_mode);
    assign y2 = model_y(a2, b2, fault_mode);

    gate_truth_table_checker u_dut (
        .clk(clk), .rst(rst), .start(start0), .y(y0), .a(a0), .b(b0), .busy(busy0),
        .done(done0), .pass(pass0), .err_count(err0), .err_vec(vec0),
        .first_fail_idx(ffi0), .first_fail_valid(ffv0));

    gate_truth_table_checker #(.LOOPS(3)) u_dut_loop3 (
        .clk(clk), .rst(rst), .start(start1), .y(y1), .a(a1), .b(b1), .busy(busy1),
        .done(done1), .pass(pass1), .err_count(err1), .err_vec(vec1),
        .first_fail_idx(ffi1), .first_fail_valid(ffv1));

    gate_truth_table_checker #(.ERR_W(2), .LOOPS(2)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start2), .y(y2), .a(a2), .b(b2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(err2), .err_vec(vec2),
        .first_fail_idx(ffi2), .first_fail_valid(ffv2));

    always_comb begin
        case (sel)
            1:       begin obs_done = done1; obs_busy = busy1; obs_ab = {a1, b1}; end
            2:       begin obs_done = done2; obs_busy = busy2; obs_ab = {a2, b2}; end
            default: begin obs_done = done0; obs_busy = busy0; obs_ab = {a0, b0}; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_start(input logic v);
        start0 = (sel == 0) ? v : 1'b0;
        start1 = (sel == 1) ? v : 1'b0;
        start2 = (sel == 2) ? v : 1'b0;
    endtask

    // Pulses start for one cycle; returns at the negedge of the first SETTLE cycle.
    task automatic kick();
        @(negedge clk);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
    endtask

    // Counts busy cycles until done (bounded), logging stimulus; optional start
    // pulse on cycle `pulse` to probe start-while-busy.
    task automatic wait_done(input int max, input int pulse, output int cycles);
        int cyc;
        cyc = 1;
        while (!obs_done && cyc <= max) begin
            ab_log[cyc]   = obs_ab;
            busy_log[cyc] = obs_busy;
            drive_start(cyc == pulse);
            @(negedge clk);
            cyc++;
        end
        drive_start(1'b0);
        cycles = cyc - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 0; fault_mode = 0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        #1;
        checks++; if ({a0, b0, busy0, done0, pass0, ffv0} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {a0, b0, busy0, done0, pass0, ffv0}); end
        checks++; if ({err0, vec0, ffi0} !== 16'h0) begin failures++; $display("FAIL reset_counters got=%h exp=0000", {err0, vec0, ffi0}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_golden();
        sel = 0; fault_mode = 0;
        kick();
        wait_done(20, 0, n);
        checks++; if (n !== 12) begin failures++; $display("FAIL golden_cycles got=%0d exp=12", n); end
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (ab_log[k] !== 2'((k - 1) / 3) || busy_log[k] !== 1'b1) begin
                failures++; $display("FAIL golden_ab_seq cyc=%0d got ab=%b busy=%b exp ab=%b busy=1", k, ab_log[k], busy_log[k], 2'((k - 1) / 3));
            end
        end
        checks++; if ({done0, busy0, pass0, ffv0} !== 4'b1010) begin failures++; $display("FAIL golden_status got=%b exp=1010", {done0, busy0, pass0, ffv0}); end
        checks++; if (err0 !== 8'd0 || vec0 !== 6'd0) begin failures++; $display("FAIL golden_errs got=%0d/%b exp=0/000000", err0, vec0); end
    endtask

    task automatic test_xor_stuck();
        sel = 0; fault_mode = 1;
        kick();
        wait_done(20, 0, n);
        checks++; if (n !== 12) begin failures++; $display("FAIL xor_cycles got=%0d exp=12", n); end
        checks++; if (err0 !== 8'd2) begin failures++; $display("FAIL xor_err_count got=%0d exp=2", err0); end
        checks++; if (vec0 !== 6'b010000) begin failures++; $display("FAIL xor_err_vec got=%b exp=010000", vec0); end
        checks++; if ({ffv0, ffi0} !== 3'b101) begin failures++; $display("FAIL xor_first_fail got=%b exp=101", {ffv0, ffi0}); end
        checks++; if ({done0, pass0} !== 2'b10) begin failures++; $display("FAIL xor_pass got=%b exp=10", {done0, pass0}); end
    endtask

    task automatic test_x_inputs();
        sel = 0; fault_mode = 4;
        kick();
        wait_done(20, 0, n);
        checks++; if (err0 !== 8'd4 || vec0 !== 6'b111111) begin failures++; $display("FAIL x_errs got=%0d/%b exp=4/111111", err0, vec0); end
        checks++; if ({ffv0, ffi0, pass0} !== 4'b1000) begin failures++; $display("FAIL x_first_fail got=%b exp=1000", {ffv0, ffi0, pass0}); end
    endtask

    task automatic test_loops3_swap();
        sel = 1; fault_mode = 2;
        kick();
        wait_done(40, 0, n);
        checks++; if (n !== 36) begin failures++; $display("FAIL loop3_cycles got=%0d exp=36", n); end
        // NAND and NOR differ only at ab=01/10: two bad samples per pass
        checks++; if (err1 !== 8'd6) begin failures++; $display("FAIL loop3_err_count got=%0d exp=6", err1); end
        checks++; if (vec1 !== 6'b001100) begin failures++; $display("FAIL loop3_err_vec got=%b exp=001100", vec1); end
        checks++; if ({ffv1, ffi1, pass1} !== 4'b1010) begin failures++; $display("FAIL loop3_first_fail got=%b exp=1010", {ffv1, ffi1, pass1}); end
    endtask

    task automatic test_back_to_back();
        sel = 0; fault_mode = 1;
        kick();
        wait_done(20, 7, n);
        checks++; if (n !== 12) begin failures++; $display("FAIL busy_start_cycles got=%0d exp=12", n); end
        checks++; if (ab_log[8] !== 2'b10 || ab_log[10] !== 2'b11) begin failures++; $display("FAIL busy_start_ab got=%b,%b exp=10,11", ab_log[8], ab_log[10]); end
        checks++; if (err0 !== 8'd2) begin failures++; $display("FAIL busy_start_err got=%0d exp=2", err0); end
        fault_mode = 0;
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        checks++; if ({done0, busy0, a0, b0} !== 4'b0100) begin failures++; $display("FAIL restart_status got=%b exp=0100", {done0, busy0, a0, b0}); end
        checks++; if ({err0, vec0, ffv0} !== 15'd0) begin failures++; $display("FAIL restart_clear got=%h exp=0000", {err0, vec0, ffv0}); end
        wait_done(20, 0, n);
        checks++; if (n !== 12 || pass0 !== 1'b1) begin failures++; $display("FAIL restart_run got=%0d/%b exp=12/1", n, pass0); end
    endtask

    task automatic test_async_reset();
        sel = 0; fault_mode = 1;
        kick();
        repeat (5) @(negedge clk);
        checks++; if ({busy0, a0, b0} !== 3'b101) begin failures++; $display("FAIL rst_pre got=%b exp=101", {busy0, a0, b0}); end
        rst = 1'b1;
        #1;
        checks++; if ({a0, b0, busy0, done0, err0} !== 12'd0) begin failures++; $display("FAIL rst_mid_run got=%h exp=000", {a0, b0, busy0, done0, err0}); end
        @(negedge clk);
        rst = 1'b0; fault_mode = 0;
        kick();
        wait_done(20, 0, n);
        checks++; if (n !== 12 || pass0 !== 1'b1 || err0 !== 8'd0) begin failures++; $display("FAIL rst_clean_run got=%0d/%b/%0d exp=12/1/0", n, pass0, err0); end
        fault_mode = 1;
        kick();
        wait_done(20, 0, n);
        #3 rst = 1'b1;
        #1;
        checks++; if ({done0, pass0, err0, vec0, ffv0} !== 17'd0) begin failures++; $display("FAIL rst_in_done got=%h exp=00000", {done0, pass0, err0, vec0, ffv0}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        sel = 2; fault_mode = 3;
        kick();
        wait_done(40, 0, n);
        checks++; if (n !== 24) begin failures++; $display("FAIL sat_cycles got=%0d exp=24", n); end
        checks++; if (err2 !== 2'b11) begin failures++; $display("FAIL sat_err_count got=%b exp=11", err2); end
        checks++; if (vec2 !== 6'b111111) begin failures++; $display("FAIL sat_err_vec got=%b exp=111111", vec2); end
        checks++; if ({done2, pass2, ffv2, ffi2} !== 5'b10100) begin failures++; $display("FAIL sat_status got=%b exp=10100", {done2, pass2, ffv2, ffi2}); end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_golden();
        test_xor_stuck();
        test_x_inputs();
        test_loops3_swap();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
